// File: rtl/store_ctrl_if.sv
// rtl/store_ctrl_if.sv - store request and memory port bundle for store_ctrl
interface store_ctrl_if;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        err;

    modport slave (
        input  start, size, addr, wdata, mem_rdata,
        output mem_addr, mem_wr, mem_wdata, busy, done, err
    );

    modport master (
        output start, size, addr, wdata, mem_rdata,
        input  mem_addr, mem_wr, mem_wdata, busy, done, err
    );
endinterface

// File: rtl/store_ctrl.sv
// rtl/store_ctrl.sv - byte/half/word store controller with read-modify-write
module store_ctrl (
    input  logic        clk,
    input  logic        reset,
    store_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, MERGE, WR, FIN} state_t;

    state_t      state_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_wr_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] merged_d;
    logic        reject;

    assign reject = (bus.size == 2'b11)
                  | ((bus.size == 2'b01) & bus.addr[0])
                  | ((bus.size == 2'b10) & (bus.addr[1:0] != 2'b00));

    // Sub-word data is patched into the captured read word; lanes are little-endian.
    always_comb begin
        merged_d = merge_q;
        if (size_q == 2'b00) begin
            merged_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (lane_q[1]) begin
            merged_d[31:16] = wdata_q;
        end else begin
            merged_d[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            wdata_q     <= 16'h0;
            merge_q     <= 32'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        size_q     <= bus.size;
                        lane_q     <= bus.addr[1:0];
                        wdata_q    <= bus.wdata[15:0];
                        mem_addr_q <= {bus.addr[31:2], 2'b00};
                        if (reject) begin
                            err_q <= 1'b1;
                        end else if (bus.size == 2'b10) begin
                            state_q     <= WR;
                            busy_q      <= 1'b1;
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= bus.wdata;
                        end else begin
                            state_q <= RD;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RD: state_q <= WAIT;
                WAIT: begin
                    // Read data is valid in WAIT, one cycle after the address went out in RD.
                    merge_q <= bus.mem_rdata;
                    state_q <= MERGE;
                end
                MERGE: begin
                    mem_wdata_q <= merged_d;
                    mem_wr_q    <= 1'b1;
                    state_q     <= WR;
                end
                WR: begin
                    mem_wr_q    <= 1'b0;
                    mem_wdata_q <= 32'h0;
                    done_q      <= 1'b1;
                    state_q     <= FIN;
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q   <= 1'b0;
                    mem_wr_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_store_ctrl.sv
// tb/tb_store_ctrl.sv - scoreboard bench for store_ctrl
module tb_store_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    store_ctrl_if bus();
    store_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } ev_t;

    ev_t         q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] mem [0:63];
    logic [31:0] rdata_q = 32'h0;
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_val = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: registered read, write on mem_wr, preload port for the stimulus.
    always @(posedge clk) begin
        rdata_q <= mem[bus.mem_addr[7:2]];
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (bus.mem_wr) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = rdata_q;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(int kind, logic [31:0] a, logic [31:0] d);
        ev_t e;
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d addr=%h data=%h expected none",
                     kind, cyc, a, d);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.c != cyc || e.a !== a || e.d !== d) begin
                n_fail++;
                $display("FAIL event: got kind=%0d cyc=%0d addr=%h data=%h expected kind=%0d cyc=%0d addr=%h data=%h",
                         kind, cyc, a, d, e.kind, e.c, e.a, e.d);
            end
        end
    endtask

    // kind 0 = write beat, 1 = done pulse, 2 = err pulse
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_wr) expect_ev(0, bus.mem_addr, bus.mem_wdata);
            if (bus.done)   expect_ev(1, 32'h0, 32'h0);
            if (bus.err)    expect_ev(2, 32'h0, 32'h0);
            if (!bus.mem_wr) check("wdata_zero_outside_wr", bus.mem_wdata, 32'h0);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(int idx, logic [31:0] v);
        pre_en  = 1'b1;
        pre_idx = idx[5:0];
        pre_val = v;
        tick(1);
        pre_en  = 1'b0;
    endtask

    task automatic push(int kind, logic [31:0] a, logic [31:0] d, int c);
        ev_t e;
        e.kind = kind; e.a = a; e.d = d; e.c = c;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        tick(1);
        while (bus.busy && n < 20) begin
            tick(1);
            n++;
        end
        check("idle_timeout", {31'h0, bus.busy}, 32'h0);
    endtask

    // exp_addr is the word address expected on the write beat.
    task automatic store(logic [1:0] sz, logic [31:0] a, logic [31:0] wd,
                         logic exp_err, logic [31:0] exp_addr, logic [31:0] exp_wd);
        int s0 = cyc;
        if (exp_err) begin
            push(2, 32'h0, 32'h0, s0 + 1);
        end else if (sz == 2'b10) begin
            push(0, exp_addr, exp_wd, s0 + 1);
            push(1, 32'h0, 32'h0, s0 + 2);
        end else begin
            push(0, exp_addr, exp_wd, s0 + 4);
            push(1, 32'h0, 32'h0, s0 + 5);
        end
        bus.start = 1'b1; bus.size = sz; bus.addr = a; bus.wdata = wd;
        tick(1);
        bus.start = 1'b0; bus.addr = 32'hFFFF_FFFF; bus.wdata = 32'hFFFF_FFFF;
        wait_idle();
    endtask

    initial begin
        int s0;
        bus.start = 1'b0; bus.size = 2'b00; bus.addr = 32'h0; bus.wdata = 32'h0;
        tick(3);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_err", {31'h0, bus.err}, 32'h0);
        check("rst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        reset = 1'b0;

        preload(4, 32'h0);
        preload(8, 32'h1122_3344);
        preload(16, 32'hAABB_CCDD);
        preload(12, 32'hFFFF_FFFF);
        preload(63, 32'h0102_0304);

        store(2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        store(2'b00, 32'h22, 32'h0000_00AB, 1'b0, 32'h20, 32'h11AB_3344);
        check("sb_mem", mem[8], 32'h11AB_3344);
        store(2'b01, 32'h42, 32'h0000_1234, 1'b0, 32'h40, 32'h1234_CCDD);
        preload(16, 32'hAABB_CCDD);
        store(2'b01, 32'h40, 32'h0000_1234, 1'b0, 32'h40, 32'hAABB_1234);
        store(2'b00, 32'h31, 32'h1234_565A, 1'b0, 32'h30, 32'hFFFF_5AFF);
        store(2'b00, 32'hFFFF_FFFF, 32'h0000_0077, 1'b0, 32'hFFFF_FFFC, 32'h7702_0304);

        store(2'b10, 32'h13, 32'h5555_5555, 1'b1, 32'h0, 32'h0);
        store(2'b01, 32'h41, 32'h0000_5555, 1'b1, 32'h0, 32'h0);
        store(2'b11, 32'h00, 32'h0000_5555, 1'b1, 32'h0, 32'h0);
        check("misaligned_mem_unchanged", mem[16], 32'hAABB_1234);

        // start held high across two byte stores; the second only lands after FIN.
        preload(20, 32'h0);
        s0 = cyc;
        push(0, 32'h50, 32'h0000_00CC, s0 + 4);
        push(1, 32'h0, 32'h0, s0 + 5);
        push(0, 32'h50, 32'hDD00_00CC, s0 + 10);
        push(1, 32'h0, 32'h0, s0 + 11);
        bus.start = 1'b1; bus.size = 2'b00; bus.addr = 32'h50; bus.wdata = 32'hCC;
        tick(1);
        bus.addr = 32'h53; bus.wdata = 32'hDD;
        tick(6);
        bus.start = 1'b0;
        wait_idle();
        check("held_start_mem", mem[20], 32'hDD00_00CC);

        // Reset during WAIT of a byte store aborts it.
        preload(9, 32'h5566_7788);
        bus.start = 1'b1; bus.size = 2'b00; bus.addr = 32'h24; bus.wdata = 32'h99;
        tick(1);
        bus.start = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("abort_busy", {31'h0, bus.busy}, 32'h0);
        check("abort_done", {31'h0, bus.done}, 32'h0);
        check("abort_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
        check("abort_mem_addr", bus.mem_addr, 32'h0);
        check("abort_mem_wdata", bus.mem_wdata, 32'h0);
        tick(8);
        check("abort_mem_unchanged", mem[9], 32'h5566_7788);

        // Reset wins over start on the same edge.
        reset = 1'b1; bus.start = 1'b1; bus.size = 2'b10; bus.addr = 32'h0;
        tick(1);
        reset = 1'b0; bus.start = 1'b0;
        check("rst_priority_busy", {31'h0, bus.busy}, 32'h0);
        tick(5);

        check("pending_events", q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
